// File: rtl/rgb_pixel_fetch_pkg.sv
// rgb_pixel_fetch_pkg: SRAM base address of the RGB frame and the fetcher/unpacker state types.
package rgb_pixel_fetch_pkg;
   localparam logic [17:0] RGB_BASE = 18'd146944;
   typedef enum logic [1:0] {S_RF_IDLE, S_RF_FETCH, S_RF_DRAIN, S_RF_DONE} RGB_fetch_state_type;
   typedef enum logic [1:0] {U_W0, U_W1, U_W2} RGB_unpack_state_type;
endpackage

// File: rtl/rgb_word_fifo.sv
// rgb_word_fifo: 16-bit synchronous word FIFO; a push and pop together while empty pass the word straight through.
module rgb_word_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       push_i,
   input  logic [15:0]                data_i,
   input  logic                       pop_i,
   output logic [15:0]                data_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       empty_o,
   output logic                       full_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [CW-1:0] count_q, count_d;
   logic          wr_en, rd_en;
   assign empty_o = count_q == '0;
   assign full_o  = count_q == CW'(DEPTH);
   assign count_o = count_q;
   assign data_o  = empty_o ? data_i : mem_q[rp_q];
   always_comb begin
      wr_en   = push_i && (empty_o ? !pop_i : (!full_o || pop_i));
      rd_en   = pop_i && !empty_o;
      count_d = count_q + CW'(wr_en) - CW'(rd_en);
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wr_en ? wp_q + AW'(1) : wp_q;
         rp_q    <= rd_en ? rp_q + AW'(1) : rp_q;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk_i)
      if (wr_en) mem_q[wp_q] <= data_i;
endmodule

// File: rtl/rgb_pixel_fetch.sv
// rgb_pixel_fetch: streams the packed RGB frame out of SRAM, unpacking 3 words into 2 pixels on a valid/ready port.
// Define FRAME_CHECKSUM_EN to add frame_checksum, the mod-2^16 sum of R+G+B over the accepted frame.
module rgb_pixel_fetch #(
   parameter int PIXELS_PER_ROW = 320,
   parameter int ROWS           = 240,
   parameter int FIFO_DEPTH     = 4,
   parameter int SRAM_LATENCY   = 2
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Enable,
   output logic [17:0] SRAM_address,
   input  logic [15:0] SRAM_read_data,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic        pixel_valid,
   input  logic        pixel_ready,
   output logic [7:0]  pixel_R,
   output logic [7:0]  pixel_G,
   output logic [7:0]  pixel_B,
   output logic        frame_start,
   output logic        line_end,
   output logic        Done
`ifdef FRAME_CHECKSUM_EN
   ,output logic [15:0] frame_checksum
`endif
);
   import rgb_pixel_fetch_pkg::*;
   localparam int N_WORDS = ROWS * PIXELS_PER_ROW * 3 / 2;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   RGB_fetch_state_type     fs_q, fs_d;
   RGB_unpack_state_type    us_q, us_d;
   logic [16:0]             wcnt_q, wcnt_d;
   logic [17:0]             addr_q, addr_d;
   logic [SRAM_LATENCY-1:0] vld_q;
   logic [15:0]             hold_q, hold_d;
   logic                    pv_q, pv_d;
   logic [7:0]              r_q, r_d, g_q, g_d, b_q, b_d, row_q, row_d;
   logic [8:0]              col_q, col_d;
   logic [15:0]             fifo_data;
   logic [CW-1:0]           fifo_cnt;
   logic                    fifo_empty, fifo_full, push, pop, issue, accept, last_col, last_acc, start;
   // Credit covers both buffered words and reads still in the SRAM pipe, so the FIFO can never overflow.
   assign push     = vld_q[SRAM_LATENCY-1];
   assign issue    = fs_q == S_RF_FETCH && !fifo_full && (int'(fifo_cnt) + $countones(vld_q) < FIFO_DEPTH);
   assign accept   = pv_q && pixel_ready;
   assign pop      = (!fifo_empty || push) && (!pv_q || pixel_ready);
   assign last_col = col_q == 9'(PIXELS_PER_ROW - 1);
   assign last_acc = accept && last_col && row_q == 8'(ROWS - 1);
   assign start    = fs_q == S_RF_IDLE && Enable;
   rgb_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i(Clock), .rst_n_i(Resetn), .push_i(push), .data_i(SRAM_read_data), .pop_i(pop),
      .data_o(fifo_data), .count_o(fifo_cnt), .empty_o(fifo_empty), .full_o(fifo_full)
   );
   always_comb begin
      fs_d   = fs_q;
      wcnt_d = start ? 17'd0 : wcnt_q;
      addr_d = addr_q;
      case (fs_q)
         S_RF_IDLE:  fs_d = Enable ? S_RF_FETCH : S_RF_IDLE;
         S_RF_FETCH: fs_d = (issue && wcnt_q == 17'(N_WORDS - 1)) ? S_RF_DRAIN : S_RF_FETCH;
         S_RF_DRAIN: fs_d = last_acc ? S_RF_DONE : S_RF_DRAIN;
         default:    fs_d = S_RF_IDLE;
      endcase
      if (issue) begin
         addr_d = RGB_BASE + 18'(wcnt_q);
         wcnt_d = wcnt_q + 17'd1;
      end
   end
   // w0={R_e,G_e} w1={B_e,R_o} w2={G_o,B_o}; R_o waits in hold_q[7:0] until w2 arrives.
   always_comb begin
      us_d   = us_q;
      hold_d = hold_q;
      pv_d   = accept ? 1'b0 : pv_q;
      r_d    = r_q;
      g_d    = g_q;
      b_d    = b_q;
      if (pop) begin
         case (us_q)
            U_W0: begin
               us_d   = U_W1;
               hold_d = fifo_data;
            end
            U_W1: begin
               us_d        = U_W2;
               hold_d[7:0] = fifo_data[7:0];
               pv_d        = 1'b1;
               r_d         = hold_q[15:8];
               g_d         = hold_q[7:0];
               b_d         = fifo_data[15:8];
            end
            default: begin
               us_d = U_W0;
               pv_d = 1'b1;
               r_d  = hold_q[7:0];
               g_d  = fifo_data[15:8];
               b_d  = fifo_data[7:0];
            end
         endcase
      end
      col_d = accept ? (last_col ? 9'd0 : col_q + 9'd1) : col_q;
      row_d = (accept && last_col) ? (row_q == 8'(ROWS - 1) ? 8'd0 : row_q + 8'd1) : row_q;
   end
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         fs_q   <= S_RF_IDLE;
         us_q   <= U_W0;
         wcnt_q <= '0;
         addr_q <= '0;
         vld_q  <= '0;
         hold_q <= '0;
         pv_q   <= 1'b0;
         r_q    <= '0;
         g_q    <= '0;
         b_q    <= '0;
         col_q  <= '0;
         row_q  <= '0;
      end else begin
         fs_q   <= fs_d;
         us_q   <= us_d;
         wcnt_q <= wcnt_d;
         addr_q <= addr_d;
         vld_q  <= {vld_q[SRAM_LATENCY-2:0], issue};
         hold_q <= hold_d;
         pv_q   <= pv_d;
         r_q    <= r_d;
         g_q    <= g_d;
         b_q    <= b_d;
         col_q  <= col_d;
         row_q  <= row_d;
      end
   end
`ifdef FRAME_CHECKSUM_EN
   logic [15:0] sum_q, sum_d;
   assign sum_d = start ? 16'd0 : accept ? sum_q + 16'(r_q) + 16'(g_q) + 16'(b_q) : sum_q;
   always_ff @(posedge Clock or negedge Resetn)
      if (!Resetn) sum_q <= '0;
      else sum_q <= sum_d;
   assign frame_checksum = sum_q;
`endif
   assign SRAM_address    = addr_q;
   assign SRAM_write_data = 16'd0;
   assign SRAM_we_n       = 1'b1;
   assign pixel_valid     = pv_q;
   assign pixel_R         = r_q;
   assign pixel_G         = g_q;
   assign pixel_B         = b_q;
   assign frame_start     = pv_q && col_q == 9'd0 && row_q == 8'd0;
   assign line_end        = pv_q && last_col;
   assign Done            = fs_q == S_RF_DONE;
endmodule
